// File: rtl/fb_writer_if.sv
// Pixel stream handshake into the frame-buffer writer.
// Beat {s_data,s_sof,s_eol} moves when s_valid & s_ready.
interface fb_writer_if;
  logic        s_valid;
  logic        s_ready;
  logic [11:0] s_data;
  logic        s_sof;
  logic        s_eol;

  modport master (
    output s_valid, s_data, s_sof, s_eol,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_data, s_sof, s_eol,
    output s_ready
  );
endinterface

// File: rtl/fb_writer.sv
// Raster frame-buffer writer: stream in (s), {R,B,G} writes out,
// frame_done/busy status, sticky short/long/sof line-structure errors.
module fb_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  fb_writer_if.slave        s,
  input  logic              hold,
  input  logic              clear_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              err_short,
  output logic              err_long,
  output logic              err_sof
);
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_SKIP   = 2'd2;

  logic [1:0]        state, n_state;
  logic [XW-1:0]     x, n_x, cx;
  logic [YW-1:0]     y, n_y, cy;
  logic [ADDR_W-1:0] base, n_base, cbase;
  logic              acc, restart, live;
  logic              do_wr, row_end, done;
  logic              set_short, set_long, set_sof;

  assign s.s_ready = rst & ~hold;

  always_comb begin
    acc       = s.s_valid & s.s_ready;
    restart   = acc & s.s_sof;
    // an sof beat is pixel 0 of row 0, whatever came before
    cx        = restart ? '0 : x;
    cy        = restart ? '0 : y;
    cbase     = restart ? '0 : base;
    live      = restart | (state == S_ACTIVE);
    n_state   = state;
    n_x       = x;
    n_y       = y;
    n_base    = base;
    do_wr     = 1'b0;
    row_end   = 1'b0;
    done      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    set_sof   = restart & (state != S_IDLE);
    if (acc) begin
      if (live) begin
        do_wr  = 1'b1;
        n_y    = cy;
        n_base = cbase;
        if (s.s_eol) begin
          set_short = (cx != X_LAST);
          row_end   = 1'b1;
        end else if (cx == X_LAST) begin
          set_long = 1'b1;
          n_state  = S_SKIP;
          n_x      = cx;
        end else begin
          n_state = S_ACTIVE;
          n_x     = cx + XW'(1);
        end
      end else if (state == S_SKIP && s.s_eol) begin
        row_end = 1'b1;
      end
      if (row_end) begin
        if (cy == Y_LAST) begin
          done    = 1'b1;
          n_state = S_IDLE;
          n_x     = '0;
          n_y     = '0;
          n_base  = '0;
        end else begin
          n_state = S_ACTIVE;
          n_x     = '0;
          n_y     = cy + YW'(1);
          n_base  = cbase + ROW_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      base       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      state      <= n_state;
      x          <= n_x;
      y          <= n_y;
      base       <= n_base;
      wr_en      <= do_wr;
      frame_done <= done;
      busy       <= (n_state != S_IDLE);
      if (do_wr) begin
        wr_addr <= cbase + ADDR_W'(cx);
        wr_data <= {s.s_data[11:8], s.s_data[3:0], s.s_data[7:4]};
      end
      // a set in the same cycle as clear_err wins
      err_short <= set_short | (err_short & ~clear_err);
      err_long  <= set_long  | (err_long  & ~clear_err);
      err_sof   <= set_sof   | (err_sof   & ~clear_err);
    end
  end
endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: row-level reference model,
// randomized data, lengths, hold and valid gaps.
module tb_fb_writer;
  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AW = 17;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [11:0]   data;
    bit            done;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          hold = 1'b0;
  logic          clear_err = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          busy;
  logic          err_short;
  logic          err_long;
  logic          err_sof;

  fb_writer_if sif();

  fb_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (sif),
    .hold       (hold),
    .clear_err  (clear_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .err_short  (err_short),
    .err_long   (err_long),
    .err_sof    (err_sof)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  exp_t me;
  exp_t none;
  int   errors = 0;
  int   checks = 0;
  bit   m_in, m_short, m_long, m_sof;

  function automatic logic [11:0] reorder(input logic [11:0] d);
    return {d[11:8], d[3:0], d[7:4]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (wr_en || frame_done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: we=%0b addr=%0d done=%0b cyc=%0d, want none",
                 wr_en, wr_addr, frame_done, cyc);
      end else begin
        me = q.pop_front();
        if (wr_en !== me.we || frame_done !== me.done || cyc != me.cyc ||
            (me.we && (wr_addr !== me.addr || wr_data !== me.data))) begin
          errors++;
          $display("FAIL write: got we=%0b a=%0d d=%h done=%0b cyc=%0d want we=%0b a=%0d d=%h done=%0b cyc=%0d",
                   wr_en, wr_addr, wr_data, frame_done, cyc,
                   me.we, me.addr, me.data, me.done, me.cyc);
        end
      end
    end
  end

  task automatic beat(input logic [11:0] d, input bit sof, input bit eol,
                      input bit clr, input bit stall, input bit has,
                      input exp_t e);
    int n;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        sif.s_valid = 1'b0;
        clear_err = 1'b0;
        hold = ($urandom_range(0, 1) == 1);
      end
    end
    @(negedge clk);
    clear_err   = 1'b0;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_sof   = sof;
    sif.s_eol   = eol;
    hold = stall && ($urandom_range(0, 3) == 0);
    #1;
    n = 0;
    while (hold || !sif.s_ready) begin
      @(negedge clk);
      hold = stall && ($urandom_range(0, 3) == 0);
      #1;
      n++;
      if (n > 200) begin
        $display("FAIL ready_timeout: s_ready=%0b want 1", sif.s_ready);
        $fatal(1, "handshake stuck");
      end
    end
    clear_err = clr;
    if (has) begin
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic send_line(input int row, input int len, input bit sof,
                           input bit eol, input bit clr, input bit stall,
                           input int first);
    exp_t        e;
    logic [11:0] d;
    bit          last, fe;
    if (sof) begin
      if (m_in) m_sof = 1'b1;
      m_in = 1'b1;
    end
    for (int i = 0; i < len; i++) begin
      last   = (i == len - 1);
      d      = (i == 0 && first >= 0) ? first[11:0] : 12'($urandom);
      fe     = eol && last && (row == H - 1);
      e.we   = (i < W);
      e.addr = AW'(row * W + i);
      e.data = reorder(d);
      e.done = fe;
      e.cyc  = 0;
      beat(d, sof && i == 0, eol && last, clr && last, stall,
           (i < W) || fe, e);
    end
    if (clr) begin
      m_short = 1'b0;
      m_long  = 1'b0;
      m_sof   = 1'b0;
    end
    if (len > W) m_long = 1'b1;
    if (eol && len < W) m_short = 1'b1;
    if (eol && row == H - 1) m_in = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    @(negedge clk);
    sif.s_valid = 1'b0;
    clear_err = 1'b0;
    hold = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_state(input string name);
    chk({name, "_busy"}, busy, m_in);
    chk({name, "_err_short"}, err_short, m_short);
    chk({name, "_err_long"}, err_long, m_long);
    chk({name, "_err_sof"}, err_sof, m_sof);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_wr_en"}, wr_en, 0);
    chk({name, "_wr_addr"}, wr_addr, 0);
    chk({name, "_wr_data"}, wr_data, 0);
    chk({name, "_frame_done"}, frame_done, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_errs"}, {err_short, err_long, err_sof}, 0);
    chk({name, "_s_ready"}, sif.s_ready, 0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    sif.s_valid = 1'b0;
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_sof   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    sif.s_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst = 1'b1;
    m_in    = 1'b0;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_sof   = 1'b0;
  endtask

  initial begin
    int len;
    none = '{we: 1'b0, addr: '0, data: '0, done: 1'b0, cyc: 0};
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_sof   = 1'b0;
    sif.s_eol   = 1'b0;
    m_in = 0; m_short = 0; m_long = 0; m_sof = 0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 4; i++)
      beat(12'($urandom), 1'b0, i == 2, 1'b0, 1'b0, 1'b0, none);
    drain("idle");
    check_state("idle");

    for (int r = 0; r < H; r++)
      send_line(r, W, r == 0, 1, 0, 0, (r == 0) ? 'hABC : -1);
    drain("clean");
    check_state("clean");

    for (int r = 0; r < 5; r++)
      send_line(r, W, r == 0, 1, 0, 0, -1);
    send_line(5, 100, 0, 1, 0, 0, -1);
    drain("short_mid");
    check_state("short_mid");
    for (int r = 6; r < H; r++)
      send_line(r, 1, 0, 1, 0, 0, -1);
    drain("short_end");
    check_state("short_end");

    do_clear();
    send_line(0, 330, 1, 1, 0, 0, -1);
    drain("long_row0");
    check_state("long_row0");
    send_line(1, W, 0, 1, 0, 1, -1);
    send_line(2, 325, 0, 0, 0, 1, -1);
    drain("skip");
    check_state("skip");
    send_line(0, 3, 1, 1, 0, 1, -1);
    for (int r = 1; r < H; r++)
      send_line(r, 1, 0, 1, 0, 1, -1);
    drain("skip_sof");
    check_state("skip_sof");

    do_clear();
    for (int r = 0; r < 100; r++)
      send_line(r, 1, r == 0, 1, 0, 0, -1);
    send_line(100, 50, 0, 0, 0, 0, -1);
    drain("early_pre");
    check_state("early_pre");
    send_line(0, 1, 1, 1, 0, 0, -1);
    drain("early_sof");
    check_state("early_sof");
    for (int r = 1; r < H; r++)
      send_line(r, 1, 0, 1, 0, 0, -1);
    drain("early_end");
    check_state("early_end");

    send_line(0, 10, 1, 0, 0, 0, -1);
    drain("pre_rst");
    pulse_reset();
    for (int i = 0; i < 5; i++)
      beat(12'($urandom), 1'b0, i == 3, 1'b0, 1'b1, 1'b0, none);
    drain("post_rst");
    check_state("post_rst");
    for (int r = 0; r < H; r++) begin
      len = ($urandom_range(0, 39) == 0) ? $urandom_range(W - 2, W + 2)
                                         : $urandom_range(1, 4);
      send_line(r, len, r == 0, 1, 0, 1, -1);
    end
    drain("random");
    check_state("random");

    do_clear();
    send_line(0, 7, 1, 1, 1, 0, -1);
    drain("clr_set");
    check_state("clr_set");
    for (int r = 1; r < H; r++)
      send_line(r, 1, 0, 1, 0, 1, -1);
    drain("clr_end");
    check_state("clr_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fb_writer.md
# fb_writer

Frame-buffer writer for the 320x240 RGB444 image store that the VGA display controller scans out with 2x pixel doubling. It accepts the enhanced-pixel stream from the Retinex pipeline over a valid/ready handshake with start-of-frame and end-of-line markers. It writes each pixel to the buffer's write port at a raster address, in the buffer's `{R,B,G}` word order. It checks the line and frame structure of the stream and reports violations through sticky error flags.

## Interface
- `WIDTH`, 320, pixels per stored row
- `HEIGHT`, 240, rows per stored frame
- `ADDR_W`, 17, frame-buffer address width (WIDTH*HEIGHT-1 must fit)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (low = reset)
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input pixel accepted when `s_valid & s_ready`
- `s_data`  in  12  pixel `{R[3:0],G[3:0],B[3:0]}`
- `s_sof`  in  1  beat is first pixel of a frame
- `s_eol`  in  1  beat is last pixel of a line
- `hold`  in  1  stall request from frame-buffer owner
- `clear_err`  in  1  one-cycle pulse; clears sticky errors
- `wr_en`  out  1  frame-buffer write strobe
- `wr_addr`  out  ADDR_W  write address
- `wr_data`  out  12  write word `{R,B,G}`
- `frame_done`  out  1  one-cycle pulse with the final write of a frame
- `busy`  out  1  high while a frame is in progress (ACTIVE or SKIP)
- `err_short`, `err_long`, `err_sof`  out  1 each  sticky error flags

## Operation
- **Acceptance:**
  - `s_ready = rst & ~hold`, combinational.
  - A beat is accepted only when `s_valid & s_ready`.
  - No other state advances on unaccepted cycles.
- **State IDLE:**
  - Accepted beats without `s_sof` are discarded, with no write.
  - An accepted beat with `s_sof` writes address 0, sets x=1, y=0, and moves to ACTIVE.
- **State ACTIVE:** each accepted pixel writes `y*WIDTH + x`. The address is held as an incremental row base plus column, with no multiplier. Per beat:
  - `s_sof` → sets `err_sof`. The beat is pixel 0 of a new frame: write addr 0, x=1, y=0. No `frame_done` for the aborted frame.
  - `s_eol` with x==WIDTH-1 → the row is complete. If y==HEIGHT-1: pulse `frame_done` and go to IDLE. Otherwise y+1, x=0.
  - `s_eol` with x<WIDTH-1 → the pixel is written and `err_short` is set. The row ends: next row, or frame end with `frame_done` if y==HEIGHT-1. Unwritten columns keep their old contents.
  - No `s_eol` with x==WIDTH-1 → the pixel is written, `err_long` is set, and the state moves to SKIP.
- **State SKIP:**
  - Accepted beats are discarded.
  - A beat with `s_eol` ends the row, using the same row/frame advance as a complete row, including `frame_done` on the last row.
  - A beat with `s_sof` sets `err_sof` and restarts the frame exactly as in ACTIVE.
- **Data reorder:** `wr_data = {s_data[11:8], s_data[3:0], s_data[7:4]}`.
- **Error flags:**
  - The flags are sticky.
  - `clear_err` clears them.
  - A set and a clear in the same cycle → the set wins.
- **Simultaneous `s_sof & s_eol`:** pixel 0 is written. The beat is then treated as an early eol (`err_short`, advance to row 1), unless WIDTH==1.
- **Reset mid-frame:** the frame is aborted and no `frame_done` is produced. The next frame requires `s_sof`.

## Timing
- **Write latency:** `wr_en`, `wr_addr`, `wr_data` are registered and valid exactly 1 cycle after acceptance. `wr_en` is high for one cycle per written pixel.
- **`frame_done`:** registered, high in the same cycle as the final `wr_en`.
- **`busy`:** registered; rises the cycle after the sof beat and falls the cycle after the last beat.
- **Error flags:** registered; assert the cycle after the offending beat.
- **Throughput:** one pixel per cycle sustained when `hold`=0.
- **`hold`:** a `hold` asserted between beats stalls without loss. An in-flight write (already registered) still completes.
- **Reset values:**
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `frame_done`=0, `busy`=0, all error flags 0.
  - State IDLE, x=y=0.
  - `s_ready`=0 while `rst` is low.

## Test plan
- **Clean frame:** one frame of 240 rows × 320 beats, `s_sof` on the first beat, `s_eol` every 320th beat, no stalls → 76800 writes at addresses 0..76799 in order. `frame_done` is high once, with the write to 76799. No errors.
- **Reorder and latency:** first pixel 0xABC accepted at cycle N → at cycle N+1, `wr_en`=1, `wr_addr`=0, `wr_data`=0xACB.
- **Short line:** `s_eol` at x=99 of row 5 → `err_short`=1. The next pixel goes to 6*320=1920, and the frame still ends with `frame_done`.
- **Long line:** 330 beats on row 0 with `s_eol` on the last → writes 0..319 only, 10 beats dropped, `err_long`=1. Row 1 starts at 320.
- **Early sof and mid-frame reset:**
  - Early sof: `s_sof` at row 100 → `err_sof`=1, next write at addr 0, no `frame_done`.
  - Mid-frame reset: `rst` low for 1 cycle mid-row, then beats without `s_sof` → no writes until the next `s_sof`.
- **Backpressure and clear:**
  - Random `hold` with random `s_valid` gaps → write sequence identical to the no-stall case.
  - `clear_err` coincident with a new short line → `err_short` stays 1.
